// File: rtl/transposed_fir_acc.sv
// -----------------------------------------------------------------------------
// transposed_fir_acc
//
// Accumulator stage of a transposed-form FIR filter. Per-tap products
// x[n]*h[k] arrive serially in tap order k = 0..NTAPS-1. The transposed
// partial-sum chain s[1..NTAPS-1] is updated one tap per beat. The k = 0 beat
// completes an output sample, which is rounded, shifted and reduced to 16 bits.
//
// Optional feature (compile-time macro):
//   FIR_ACC_SAT_EN  defined   -> out-of-range results saturate to 0x7FFF/0x8000
//                   undefined -> low 16 bits are output (two's-complement wrap)
//
// Parameters:
//   NTAPS   number of filter taps (2..64)
//   PROD_W  signed product width
//   ACC_W   signed partial-sum width (>= PROD_W + clog2(NTAPS), and > 16)
//   SHIFT   output right-shift / coefficient fraction bits (>= 1)
//
// Ports:
//   ap_clk       in   clock, rising edge
//   ap_rst_n     in   asynchronous active-low reset, release synchronised
//   clr          in   synchronous flush of partial sums, tap counter, output, err
//   prod_tdata   in   signed product x[n]*h[k]
//   prod_tvalid  in   product valid
//   prod_tlast   in   marks tap NTAPS-1 of the current sample
//   prod_tready  out  product accepted when prod_tvalid & prod_tready
//   y_tdata      out  signed 16-bit filter output
//   y_tvalid     out  output valid
//   y_tready     in   downstream ready
//   err          out  sticky framing error
// -----------------------------------------------------------------------------
module transposed_fir_acc #(
    parameter int NTAPS  = 8,
    parameter int PROD_W = 24,
    parameter int ACC_W  = 28,
    parameter int SHIFT  = 8
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    input  logic              clr,
    input  logic [PROD_W-1:0] prod_tdata,
    input  logic              prod_tvalid,
    input  logic              prod_tlast,
    output logic              prod_tready,
    output logic [15:0]       y_tdata,
    output logic              y_tvalid,
    input  logic              y_tready,
    output logic              err
);

    localparam int IDX_W = (NTAPS > 2) ? $clog2(NTAPS) : 1;
    // One extra bit so adding the rounding constant can never overflow.
    localparam int SUM_W = ACC_W + 1;
    localparam int EXT_W = (SUM_W > 17) ? SUM_W : 17;

    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NTAPS - 1);
    localparam logic [SUM_W-1:0] ROUND_HALF = SUM_W'(1) << (SHIFT - 1);

    // -------------------------------------------------------------------------
    // Reset: assertion is asynchronous, release passes through two flops so
    // every state flop leaves reset on a clean ap_clk edge.
    // -------------------------------------------------------------------------
    logic [1:0] r_rst_sync;
    logic       w_rst_n;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_rst_n = r_rst_sync[1];

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic signed [ACC_W-1:0] r_s [1:NTAPS-1];
    logic        [IDX_W-1:0] r_tap_idx;
    logic        [15:0]      r_y_data;
    logic                    r_y_valid;
    logic                    r_err;

    // -------------------------------------------------------------------------
    // Handshakes
    // -------------------------------------------------------------------------
    logic w_y_fire;
    logic w_beat;
    logic w_k0;

    // Stall products only while a finished output is waiting downstream.
    assign prod_tready = ~(r_y_valid & ~y_tready);
    assign w_y_fire    = r_y_valid & y_tready;
    // clr wins over a simultaneous beat, which is dropped.
    assign w_beat      = prod_tvalid & prod_tready & ~clr;
    assign w_k0        = w_beat & (r_tap_idx == '0);

    // -------------------------------------------------------------------------
    // Datapath
    // -------------------------------------------------------------------------
    logic signed [ACC_W-1:0] w_p;
    logic signed [ACC_W-1:0] w_acc;
    logic signed [SUM_W-1:0] w_rnd;
    logic signed [SUM_W-1:0] w_shr;
    logic        [15:0]      w_y_next;
    logic signed [ACC_W-1:0] w_s_next [1:NTAPS-1];

    assign w_p   = ACC_W'($signed(prod_tdata));
    assign w_acc = w_p + r_s[1];
    assign w_rnd = SUM_W'(w_acc) + $signed(ROUND_HALF);
    assign w_shr = w_rnd >>> SHIFT;

    // s[k] takes the product plus the not-yet-updated s[k+1]; the last tap has
    // no successor and just stores the product.
    for (genvar j = 1; j < NTAPS; j++) begin : g_tap
        if (j == NTAPS - 1) begin : g_last
            assign w_s_next[j] = w_p;
        end else begin : g_mid
            assign w_s_next[j] = w_p + r_s[j+1];
        end
    end

`ifdef FIR_ACC_SAT_EN
    localparam logic signed [EXT_W-1:0] Y_MAX = EXT_W'(32767);
    localparam logic signed [EXT_W-1:0] Y_MIN = EXT_W'(-32768);

    logic signed [EXT_W-1:0] w_ext;

    assign w_ext = EXT_W'(w_shr);

    always_comb begin
        w_y_next = w_ext[15:0];
        if (w_ext > Y_MAX) begin
            w_y_next = 16'h7fff;
        end else if (w_ext < Y_MIN) begin
            w_y_next = 16'h8000;
        end
    end
`else
    logic w_unused_hi;

    // Wrap mode keeps only the low 16 bits of the shifted sum.
    assign w_y_next    = w_shr[15:0];
    assign w_unused_hi = ^w_shr[SUM_W-1:16];
`endif

    // -------------------------------------------------------------------------
    // Partial-sum chain
    // -------------------------------------------------------------------------
    always_ff @(posedge ap_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            for (int j = 1; j < NTAPS; j++) begin
                r_s[j] <= '0;
            end
        end else if (clr) begin
            for (int j = 1; j < NTAPS; j++) begin
                r_s[j] <= '0;
            end
        end else if (w_beat) begin
            for (int j = 1; j < NTAPS; j++) begin
                if (r_tap_idx == IDX_W'(j)) begin
                    r_s[j] <= w_s_next[j];
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Tap counter and framing error
    // -------------------------------------------------------------------------
    always_ff @(posedge ap_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_tap_idx <= '0;
            r_err     <= 1'b0;
        end else if (clr) begin
            r_tap_idx <= '0;
            r_err     <= 1'b0;
        end else if (w_beat) begin
            if (prod_tlast) begin
                r_tap_idx <= '0;
                if (r_tap_idx != LAST_IDX) begin
                    r_err <= 1'b1;
                end
            end else if (r_tap_idx == LAST_IDX) begin
                // Missing tlast: flag it and realign to the next sample.
                r_err     <= 1'b1;
                r_tap_idx <= '0;
            end else begin
                r_tap_idx <= r_tap_idx + 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Output register. A k = 0 beat can only be accepted when the register is
    // empty or being drained this cycle, so reloading never loses a result.
    // -------------------------------------------------------------------------
    always_ff @(posedge ap_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_y_data  <= '0;
            r_y_valid <= 1'b0;
        end else if (clr) begin
            r_y_valid <= 1'b0;
        end else if (w_k0) begin
            r_y_data  <= w_y_next;
            r_y_valid <= 1'b1;
        end else if (w_y_fire) begin
            r_y_valid <= 1'b0;
        end
    end

    assign y_tdata  = r_y_data;
    assign y_tvalid = r_y_valid;
    assign err      = r_err;

endmodule

// File: tb/tb_transposed_fir_acc.sv
module tb_transposed_fir_acc;

    localparam int NTAPS  = 4;
    localparam int PROD_W = 24;
    localparam int ACC_W  = 28;
    localparam int SHIFT  = 8;

    logic              ap_clk      = 1'b0;
    logic              ap_rst_n    = 1'b1;
    logic              clr         = 1'b0;
    logic [PROD_W-1:0] prod_tdata  = '0;
    logic              prod_tvalid = 1'b0;
    logic              prod_tlast  = 1'b0;
    logic              prod_tready;
    logic [15:0]       y_tdata;
    logic              y_tvalid;
    logic              y_tready    = 1'b1;
    logic              err;

    transposed_fir_acc #(
        .NTAPS (NTAPS),
        .PROD_W(PROD_W),
        .ACC_W (ACC_W),
        .SHIFT (SHIFT)
    ) dut (
        .ap_clk     (ap_clk),
        .ap_rst_n   (ap_rst_n),
        .clr        (clr),
        .prod_tdata (prod_tdata),
        .prod_tvalid(prod_tvalid),
        .prod_tlast (prod_tlast),
        .prod_tready(prod_tready),
        .y_tdata    (y_tdata),
        .y_tvalid   (y_tvalid),
        .y_tready   (y_tready),
        .err        (err)
    );

    always #5 ap_clk = ~ap_clk;

    int          n_cmp = 0;
    int          n_mis = 0;
    int          last_stalls = 0;
    logic [15:0] sb[$];
    // hist[d][k]: product of tap k for the sample d samples ago (direct form).
    longint      hist[4][4];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] ref_out(input longint acc);
        longint r;
        r = (acc + (longint'(1) << (SHIFT - 1))) >>> SHIFT;
`ifdef FIR_ACC_SAT_EN
        if (r > 32767) return 16'h7fff;
        if (r < -32768) return 16'h8000;
`endif
        return r[15:0];
    endfunction

    task automatic clear_model();
        for (int d = 0; d < 4; d++)
            for (int k = 0; k < 4; k++) hist[d][k] = 0;
    endtask

    // Direct-form reference: y[n] = sum_k p[n-k][k]; taps never sent count as 0.
    task automatic push_expected(input longint p0, p1, p2, p3, input int nbeats);
        longint row[4];
        longint acc;
        row = '{p0, p1, p2, p3};
        for (int k = nbeats; k < 4; k++) row[k] = 0;
        for (int d = 3; d > 0; d--) hist[d] = hist[d-1];
        hist[0] = row;
        acc = hist[0][0] + hist[1][1] + hist[2][2] + hist[3][3];
        sb.push_back(ref_out(acc));
    endtask

    task automatic send_beat(input longint p, input logic last);
        int   stalls = 0;
        logic took = 1'b0;
        prod_tdata  = p[PROD_W-1:0];
        prod_tlast  = last;
        prod_tvalid = 1'b1;
        do begin
            @(negedge ap_clk);
            took = prod_tready;
            @(posedge ap_clk);
            #1;
            if (!took) stalls++;
        end while (!took && stalls < 50);
        prod_tvalid = 1'b0;
        prod_tlast  = 1'b0;
        last_stalls = stalls;
        if (!took) check("beat_accept_timeout", 32'(took), 32'd1);
    endtask

    task automatic send_sample(input longint p0, p1, p2, p3);
        push_expected(p0, p1, p2, p3, 4);
        send_beat(p0, 1'b0);
        send_beat(p1, 1'b0);
        send_beat(p2, 1'b0);
        send_beat(p3, 1'b1);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge ap_clk);
            #1;
            n++;
        end
        check("drain", sb.size(), 0);
    endtask

    task automatic do_clr(input logic with_beat);
        clr         = 1'b1;
        prod_tvalid = with_beat;
        prod_tdata  = 24'h012345;
        @(posedge ap_clk);
        #1;
        clr         = 1'b0;
        prod_tvalid = 1'b0;
        clear_model();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ydata"}, 32'(y_tdata), 32'd0);
        check({tag, "_yvalid"}, 32'(y_tvalid), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
        check({tag, "_tready"}, 32'(prod_tready), 32'd1);
    endtask

    // Scoreboard: an output transfer happens on the edge following this negedge.
    always @(negedge ap_clk) begin
        if (y_tvalid && y_tready) begin
            n_cmp++;
            assert (sb.size() > 0)
            else begin
                n_mis++;
                $error("FAIL y_unexpected: observed %0h expected no output", y_tdata);
            end
            if (sb.size() > 0) check("y_data", 32'(y_tdata), 32'(sb.pop_front()));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        longint r[4];
        clear_model();

        // Reset state
        #1 ap_rst_n = 1'b0;
        #1 check_reset_outputs("reset");
        repeat (3) @(posedge ap_clk);
        #1 ap_rst_n = 1'b1;
        repeat (4) @(posedge ap_clk);
        #1 check_reset_outputs("post_reset");

        // Impulse: expect 1,2,3,4,0
        send_sample(256, 512, 768, 1024);
        for (int i = 0; i < 4; i++) send_sample(0, 0, 0, 0);
        wait_drain();

        // Random products
        for (int i = 0; i < 6; i++) begin
            for (int k = 0; k < 4; k++)
                r[k] = longint'($urandom_range(0, 2 ** 21)) - 2 ** 20;
            send_sample(r[0], r[1], r[2], r[3]);
        end
        wait_drain();

        // Backpressure: y_tready low for 5 cycles after y_tvalid
        y_tready = 1'b0;
        push_expected(3000, -5000, 7000, 90000, 4);
        send_beat(3000, 1'b0);
        prod_tdata  = 24'(-5000);
        prod_tvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge ap_clk);
            check("bp_tready", 32'(prod_tready), 32'd0);
            check("bp_yvalid", 32'(y_tvalid), 32'd1);
            check("bp_hold", 32'(y_tdata), 32'(sb[0]));
            @(posedge ap_clk);
            #1;
        end
        y_tready = 1'b1;
        send_beat(-5000, 1'b0);
        check("bp_release_stalls", last_stalls, 0);
        send_beat(7000, 1'b0);
        send_beat(90000, 1'b1);
        send_sample(100, 200, 300, 400);
        send_sample(-256, 0, 0, 0);
        check("full_rate_stalls", last_stalls, 0);
        for (int i = 0; i < 3; i++) send_sample(0, 0, 0, 0);
        wait_drain();

        // Framing error: tlast at k=2, next beat is k=0
        do_clr(1'b0);
        check("clr_err", 32'(err), 32'd0);
        push_expected(2560, 5120, 7680, 0, 3);
        send_beat(2560, 1'b0);
        check("latency_yvalid", 32'(y_tvalid), 32'd1);
        send_beat(5120, 1'b0);
        send_beat(7680, 1'b1);
        check("err_set", 32'(err), 32'd1);
        send_sample(1280, 0, 0, 0);
        check("err_sticky", 32'(err), 32'd1);
        for (int i = 0; i < 3; i++) send_sample(0, 0, 0, 0);
        wait_drain();
        // clr with a simultaneous beat: beat must be dropped
        do_clr(1'b1);
        check("clr_err_cleared", 32'(err), 32'd0);
        check("clr_yvalid", 32'(y_tvalid), 32'd0);

        // Overflow boundary: four samples of max positive products
        for (int i = 0; i < 4; i++) send_sample(8388607, 8388607, 8388607, 8388607);
        for (int i = 0; i < 3; i++) send_sample(0, 0, 0, 0);
        wait_drain();
        do_clr(1'b0);

        // Reset mid-sample after k=1
        push_expected(1000, 2000, 3000, 4000, 4);
        send_beat(1000, 1'b0);
        send_beat(2000, 1'b0);
        check("pre_reset_sb", sb.size(), 0);
        #1 ap_rst_n = 1'b0;
        #1 check_reset_outputs("mid_reset");
        repeat (2) @(posedge ap_clk);
        #1 ap_rst_n = 1'b1;
        clear_model();
        repeat (4) @(posedge ap_clk);
        #1;
        send_sample(256, 512, 768, 1024);
        for (int i = 0; i < 4; i++) send_sample(0, 0, 0, 0);
        wait_drain();
        check("final_err", 32'(err), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
